fpaddsub_normalize_round: RTL and testbench

Back end of the floating-point add/sub datapath, sitting downstream of the mantissa execute stage. It accepts the raw mantissa sum, the larger operand's exponent, the result sign and the guard/sticky bits over a valid/ready handshake. It normalises iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 result. Multi-cycle behaviour lets it sit on a DSP48E1 slice output without a wide combinational leading-zero shifter.

---
 rtl/fpaddsub_pkg.sv | 15 +
 rtl/fpaddsub_round_pack.sv | 32 +++
 rtl/fpaddsub_normalize_round.sv | 92 +++++++++
 tb/tb_fpaddsub_normalize_round.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared widths, FSM states and execute-stage bundle for the fp add/sub datapath
package fpaddsub_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_MAX = 255;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  typedef struct packed {
    logic [MAN_W+2:0] sum;
    logic [EXP_W-1:0] exp;
    logic             psgn;
    logic             opr;
    logic             g;
    logic             s;
  } in_bundle_t;
endpackage

// File: rtl/fpaddsub_round_pack.sv
// fpaddsub_round_pack: round-to-nearest-even, carry fix-up, overflow saturation and IEEE packing
// in : m (hidden bit + fraction), e (biased exponent with one spare bit), sgn, g, s
// out: result {sign, exponent field, fraction}, overflow, zero
module fpaddsub_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]       m,
  input  logic [EXP_W:0]       e,
  input  logic                 sgn,
  input  logic                 g,
  input  logic                 s,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 zero
);
  import fpaddsub_pkg::*;
  logic [MAN_W+1:0] mr;
  logic [MAN_W:0] mn;
  logic [EXP_W:0] en;
  logic [EXP_W-1:0] ef;
  always_comb begin
    mr = {1'b0, m} + {{(MAN_W+1){1'b0}}, g & (s | m[0])};
    mn = mr[MAN_W+1] ? mr[MAN_W+1:1] : mr[MAN_W:0];
    en = e + {{EXP_W{1'b0}}, mr[MAN_W+1]};
    overflow = en >= (EXP_W+1)'(EXP_MAX);
    // a denormal whose increment reaches the hidden bit picks up the minimum exponent automatically
    ef = mn[MAN_W] ? en[EXP_W-1:0] : '0;
    result = overflow ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, ef, mn[MAN_W-1:0]};
    zero = ~overflow & ~|ef & ~|mn[MAN_W-1:0];
  end
endmodule

// File: rtl/fpaddsub_normalize_round.sv
// fpaddsub_normalize_round: iterative one-bit-per-cycle normalise, RNE round and IEEE pack
// in : clk, rst_n, InValid + {Sum, Exp, PSgn, Opr, G, S} bundle, OutReady
// out: InReady (IDLE only), OutValid, Result {sign, exponent field, fraction}, Overflow, Zero
module fpaddsub_normalize_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [MAN_W+2:0]     Sum,
  input  logic [EXP_W-1:0]     Exp,
  input  logic                 PSgn,
  input  logic                 Opr,
  input  logic                 G,
  input  logic                 S,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [EXP_W+MAN_W:0] Result,
  output logic                 Overflow,
  output logic                 Zero
);
  import fpaddsub_pkg::*;
  state_t state, state_nx;
  in_bundle_t ib;
  logic [MAN_W:0] m, m_sh;
  logic [EXP_W:0] e, e_dec;
  logic sgn, g, s, carry, zero_in, skip_norm;
  logic [EXP_W+MAN_W:0] res;
  logic ov, z, unused_borrow;
  assign ib = {Sum, Exp, PSgn, Opr, G, S};
  assign unused_borrow = ib.sum[MAN_W+2];
  always_comb begin
    InReady = state == IDLE;
    OutValid = state == OUT;
    carry = ~ib.opr & ib.sum[MAN_W+1];
    zero_in = ~|ib.sum[MAN_W+1:0] & ~ib.g;
    // exponent 1 is already the denormal floor, so an unnormalised value there is left unshifted
    skip_norm = carry | zero_in | ib.sum[MAN_W] | (ib.exp == EXP_W'(1));
    m_sh = {m[MAN_W-1:0], g};
    e_dec = e - (EXP_W+1)'(1);
    state_nx = state;
    case (state)
      IDLE:    if (InValid) state_nx = skip_norm ? ROUND : NORM;
      NORM:    if (m_sh[MAN_W] | (e_dec == (EXP_W+1)'(1))) state_nx = ROUND;
      ROUND:   state_nx = OUT;
      OUT:     if (OutReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      m <= '0;
      e <= '0;
      sgn <= 1'b0;
      g <= 1'b0;
      s <= 1'b0;
      Result <= '0;
      Overflow <= 1'b0;
      Zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (InValid && state == IDLE) begin
        m <= carry ? ib.sum[MAN_W+1:1] : ib.sum[MAN_W:0];
        e <= {1'b0, ib.exp} + {{EXP_W{1'b0}}, carry};
        sgn <= ib.psgn & ~zero_in;
        g <= carry ? ib.sum[0] : ib.g;
        s <= carry ? ib.g | ib.s : ib.s;
      end else if (state == NORM) begin
        m <= m_sh;
        g <= 1'b0;
        e <= e_dec;
      end
      if (state == ROUND) begin
        Result <= res;
        Overflow <= ov;
        Zero <= z;
      end
    end
  fpaddsub_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .m(m),
    .e(e),
    .sgn(sgn),
    .g(g),
    .s(s),
    .result(res),
    .overflow(ov),
    .zero(z)
  );
endmodule

// File: tb/tb_fpaddsub_normalize_round.sv
// tb_fpaddsub_normalize_round: randomized scoreboard bench against a behavioural float model
module tb_fpaddsub_normalize_round;
  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        z;
    int          due;
  } exp_t;
  logic clk = 0, rst_n = 0, InValid = 0, OutReady = 0, PSgn = 0, Opr = 0, G = 0, S = 0;
  logic [25:0] Sum = 0;
  logic [7:0] Exp = 0;
  logic InReady, OutValid, Overflow, Zero;
  logic [31:0] Result;
  int checks = 0, failures = 0, cyc = 0;
  bit ready_en = 1, holding = 0;
  logic [33:0] held;
  exp_t q[$];
  exp_t cur;

  fpaddsub_normalize_round dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Sum(Sum), .Exp(Exp), .PSgn(PSgn), .Opr(Opr), .G(G), .S(S),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Overflow(Overflow), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Value-level model: align, shift while below 1.0 and above the denormal floor, then RNE.
  task automatic model(input logic [25:0] sm, input int ex, input bit ps, input bit op,
                       input bit gi, input bit si, output logic [31:0] res,
                       output logic ov, output logic z, output int k);
    longint m;
    int e, ef;
    bit sg, gg, ss;
    m = longint'(sm[24:0]);
    e = ex;
    sg = ps;
    gg = gi;
    ss = si;
    k = 0;
    if (!op && sm[24]) begin
      gg = sm[0];
      ss = gi | si;
      m = m / 2;
      e++;
    end else if (m == 0 && !gi) sg = 0;
    else
      while (m < 2**23 && e > 1) begin
        m = 2 * m + longint'(gg);
        gg = 0;
        e--;
        k++;
      end
    if (gg && (ss || m % 2 == 1)) m++;
    if (m >= 2**24) begin
      m = m / 2;
      e++;
    end
    ef = (m >= 2**23) ? e : 0;
    ov = e >= 255;
    z = !ov && ef == 0 && m % 2**23 == 0;
    res = ov ? {sg, 8'hFF, 23'h0} : {sg, 8'(ef), 23'(m % 2**23)};
  endtask

  task automatic send(input logic [25:0] sm, input logic [7:0] ex, input bit ps, input bit op,
                      input bit gi, input bit si);
    exp_t t;
    int k, n;
    model(sm, int'(ex), ps, op, gi, si, t.res, t.ov, t.z, k);
    @(negedge clk);
    Sum = sm;
    Exp = ex;
    PSgn = ps;
    Opr = op;
    G = gi;
    S = si;
    InValid = 1;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) chk("accept_timeout", 64'(InReady), 1);
    t.due = cyc + 2 + k;
    q.push_back(t);
    @(posedge clk);
    #1 InValid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 0;
      OutReady = 0;
    end else begin
      if (OutValid) begin
        if (!holding) begin
          chk("out_expected", 64'(q.size() != 0), 1);
          if (q.size() != 0) begin
            cur = q[0];
            chk("result", 64'(Result), 64'(cur.res));
            chk("overflow", 64'(Overflow), 64'(cur.ov));
            chk("zero", 64'(Zero), 64'(cur.z));
            chk("latency", 64'(cyc), 64'(cur.due));
          end
          holding = 1;
          held = {Overflow, Zero, Result};
        end else chk("hold_stable", 64'({Overflow, Zero, Result}), 64'(held));
        chk("inready_busy", 64'(InReady), 0);
      end else if (holding) chk("valid_held", 64'(OutValid), 1);
      OutReady = ready_en && ($urandom_range(0, 3) != 0);
      if (OutReady && OutValid) begin
        if (q.size() != 0) q.delete(0);
        holding = 0;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_inready", 64'(InReady), 1);
    chk("rst_outvalid", 64'(OutValid), 0);
    chk("rst_result", 64'(Result), 0);
    chk("rst_overflow", 64'(Overflow), 0);
    chk("rst_zero", 64'(Zero), 0);
    rst_n = 1;
    send(26'h1000000, 8'd127, 0, 0, 0, 0);
    send(26'h0400000, 8'd127, 0, 1, 0, 0);
    send(26'h0000000, 8'd127, 1, 1, 0, 0);
    send(26'h0800001, 8'd127, 0, 0, 1, 0);
    send(26'h0800002, 8'd127, 0, 0, 1, 0);
    send(26'h1000000, 8'd254, 0, 0, 0, 0);
    send(26'h0040000, 8'd3, 0, 1, 0, 0);
    send(26'h07FFFFF, 8'd1, 0, 1, 1, 1);
    drain();
    ready_en = 0;
    send(26'h0400000, 8'd127, 0, 1, 0, 0);
    repeat (6) @(negedge clk);
    chk("bp_outvalid", 64'(OutValid), 1);
    chk("bp_inready", 64'(InReady), 0);
    chk("bp_result", 64'(Result), 64'(32'h3F000000));
    ready_en = 1;
    drain();
    for (int i = 0; i < 250; i++) begin
      int cat;
      logic [25:0] sm;
      logic [7:0] ex;
      bit op, gi;
      cat = $urandom_range(0, 3);
      gi = 1'($urandom);
      op = 1'($urandom);
      ex = ($urandom_range(0, 5) == 0) ? 8'd254 : 8'($urandom_range(1, 254));
      sm = {1'($urandom), 2'b01, 23'($urandom)};
      if (cat == 0) begin
        op = 0;
        sm = {1'($urandom), 1'b1, 24'($urandom)};
      end else if (cat == 2) begin
        op = 1;
        sm = 26'(32'($urandom_range(1, 32'h7FFFFF)) >> $urandom_range(0, 22));
        if (sm == 0) sm = 26'd1;
        ex = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(2, 30)) : 8'($urandom_range(2, 254));
      end else if (cat == 3) begin
        sm = {1'($urandom), 25'd0};
        gi = 0;
      end
      send(sm, ex, 1'($urandom), op, gi, 1'($urandom));
    end
    drain();
    send(26'h0000001, 8'd100, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midnorm_outvalid", 64'(OutValid), 0);
    chk("midnorm_inready", 64'(InReady), 1);
    chk("midnorm_result", 64'(Result), 0);
    chk("midnorm_flags", 64'({Overflow, Zero}), 0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    send(26'h0400000, 8'd127, 1, 1, 1, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
